// File: rtl/program_sequencer_if.sv
// Command/status bundle for the program sequencer: the controller drives the
// command strobes and jump target, the sequencer returns PC, stack and error state.
interface program_sequencer_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic             Ep;
    logic             Cp;
    logic             Lp;
    logic             Call;
    logic             Ret;
    logic             err_clr;
    logic [WIDTH-1:0] busIn;
    logic [WIDTH-1:0] pc;
    logic [SP_W-1:0]  sp;
    logic             stack_full;
    logic             stack_empty;
    logic             wrap;
    logic             err_ovf;
    logic             err_unf;

    modport master (
        output Ep, Cp, Lp, Call, Ret, err_clr, busIn,
        input  pc, sp, stack_full, stack_empty, wrap, err_ovf, err_unf
    );

    modport slave (
        input  Ep, Cp, Lp, Call, Ret, err_clr, busIn,
        output pc, sp, stack_full, stack_empty, wrap, err_ovf, err_unf
    );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with jump, call/return via a small return-address stack,
// sticky stack-error flags and a tri-stated bus view of the PC.
module program_sequencer #(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    program_sequencer_if.slave sif,
    output wire [WIDTH-1:0]   busOut
);
    localparam int              SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int              IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SP_W-1:0]  r_sp;
    logic             r_wrap;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic [WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_stack_top;
    logic [SP_W-1:0]  w_sp_dec;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_unf_evt;
    logic             w_ovf_evt;
    logic             w_load;
    logic             w_inc;

    assign w_pc_inc    = r_pc + WIDTH'(1);
    assign w_sp_dec    = r_sp - SP_W'(1);
    assign w_full      = (r_sp == SP_MAX);
    assign w_empty     = (r_sp == '0);
    assign w_stack_top = r_stack[IDX_W'(w_sp_dec)];

    // Strict priority Ret > Call > Lp > Cp: a failed Ret/Call still masks the rest.
    assign w_pop     = sif.Ret && !w_empty;
    assign w_unf_evt = sif.Ret && w_empty;
    assign w_push    = !sif.Ret && sif.Call && !w_full;
    assign w_ovf_evt = !sif.Ret && sif.Call && w_full;
    assign w_load    = !sif.Ret && !sif.Call && sif.Lp;
    assign w_inc     = !sif.Ret && !sif.Call && !sif.Lp && sif.Cp;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pc      <= RESET_VECTOR;
            r_sp      <= '0;
            r_wrap    <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_wrap    <= w_inc && (r_pc == '1);
            // A new error event outranks a simultaneous clear.
            r_err_ovf <= (r_err_ovf && !sif.err_clr) || w_ovf_evt;
            r_err_unf <= (r_err_unf && !sif.err_clr) || w_unf_evt;
            if (w_pop) begin
                r_pc <= w_stack_top;
                r_sp <= w_sp_dec;
            end else if (w_push) begin
                r_pc <= sif.busIn;
                r_sp <= r_sp + SP_W'(1);
            end else if (w_load) begin
                r_pc <= sif.busIn;
            end else if (w_inc) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    // Entries at or above sp are never read, so the stack needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[IDX_W'(r_sp)] <= w_pc_inc;
        end
    end

    assign sif.pc          = r_pc;
    assign sif.sp          = r_sp;
    assign sif.stack_full  = w_full;
    assign sif.stack_empty = w_empty;
    assign sif.wrap        = r_wrap;
    assign sif.err_ovf     = r_err_ovf;
    assign sif.err_unf     = r_err_unf;

    assign busOut = sif.Ep ? r_pc : {WIDTH{1'bz}};
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, address/bus width in bits (SHALL be >= 2).
REQ-002 Parameter: STACK_DEPTH, default 4, number of return-address stack entries (SHALL be >= 1).
REQ-003 Parameter: RESET_VECTOR, default 0, PC value loaded at reset (WIDTH bits).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clr_n  input  1  reset, asynchronous, active-low.
REQ-006 Ep  input  1  bus output enable.
REQ-007 Cp  input  1  increment PC.
REQ-008 Lp  input  1  load PC from busIn (jump).
REQ-009 Call  input  1  push return address, then jump to busIn.
REQ-010 Ret  input  1  pop return address into PC.
REQ-011 err_clr  input  1  clear sticky error flags.
REQ-012 busIn  input  WIDTH  jump/call target.
REQ-013 busOut  output  WIDTH  PC when Ep=1, else all bits high-impedance.
REQ-014 pc  output  WIDTH  current PC, always driven.
REQ-015 sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-016 stack_full / stack_empty  output  1 each  sp==STACK_DEPTH / sp==0, combinational from sp.
REQ-017 wrap  output  1  registered one-cycle pulse, high the cycle after an increment from all-ones to zero.
REQ-018 err_ovf / err_unf  output  1 each  sticky: Call while full / Ret while empty.

Function
REQ-019 Command priority each edge SHALL be Ret > Call > Lp > Cp > hold; only the highest asserted command executes.
REQ-020 Cp: PC <= PC+1 modulo 2^WIDTH; all-ones -> 0 with wrap=1 the following cycle; wrap=0 in every other cycle.
REQ-021 Lp: PC <= busIn; stack unchanged.
REQ-022 Call, not full: stack[sp] <= PC+1 (mod 2^WIDTH), sp <= sp+1, PC <= busIn, same edge.
REQ-023 Call, full: PC, sp, stack unchanged; err_ovf <= 1.
REQ-024 Ret, not empty: PC <= stack[sp-1], sp <= sp-1.
REQ-025 Ret, empty: PC, sp unchanged; err_unf <= 1.
REQ-026 Call/Ret return-address computation SHALL NOT assert wrap; only the Cp path asserts wrap.
REQ-027 err_clr clears both error flags; a new error event in the same cycle as err_clr SHALL win (flag reads 1).
REQ-028 busOut SHALL track pc combinationally while Ep=1; Ep SHALL have no effect on state.
REQ-029 Latency: every command visible on pc/sp one cycle after the sampling edge; no multicycle operations.
REQ-030 Stack entries above sp are don't-care; they are not read before being rewritten.

Reset
REQ-031 clr_n=0 SHALL immediately, without a clock edge, force pc=RESET_VECTOR, sp=0, wrap=0, err_ovf=0, err_unf=0.
REQ-032 Stack contents need not be cleared; sp=0 makes them invalid.
REQ-033 Reset asserted mid-sequence (e.g., during a Call) SHALL abort the operation; the first command after deassertion executes against reset state.
REQ-034 Commands on the first rising edge after clr_n deassertion SHALL be honoured.

Verification
REQ-035 WIDTH=4: reset, then Cp held 17 cycles -> pc 0,1..15,0,1; wrap high only in the cycle pc reads 0 after 15.
REQ-036 Call busIn=0x40 at pc=0x10, Cp on 2 cycles, Ret -> pc 0x40,0x41,0x42,0x11; sp 1,1,1,0.
REQ-037 STACK_DEPTH=4: five Calls (targets 0x20..0x24) -> sp=4, stack_full=1, pc=0x23, err_ovf=1; four Rets restore return addresses in LIFO order; fifth Ret -> pc unchanged, err_unf=1.
REQ-038 Ret+Call+Lp+Cp asserted together with sp=1 -> Ret executes only (pc=stack top, sp=0); Lp+Cp together -> pc=busIn.
REQ-039 Ep toggled 0/1 while counting -> busOut alternates Z / pc; pc sequence unchanged.
REQ-040 clr_n pulsed low between clock edges with sp=2, err_ovf=1 -> pc=RESET_VECTOR, sp=0, err_ovf=0 before the next edge; err_clr with simultaneous overflow Call -> err_ovf stays 1.
